// File: rtl/fifo_burst_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_burst_rd_ctrl_if
// Bundles the two handshakes of the burst read controller:
//   FIFO side   : i_fifo_push (accepted write), i_fifo_valid_m (not empty),
//                 i_fifo_dataout (FWFT head), o_fifo_ready_m (pop request)
//   stream side : o_valid/o_data/o_sop/o_eop towards the consumer,
//                 i_ready back from the consumer
// master = the controller, slave = the FIFO/consumer environment.
// ---------------------------------------------------------------------------
interface fifo_burst_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_fifo_push;
  logic                  i_fifo_valid_m;
  logic [DATA_WIDTH-1:0] i_fifo_dataout;
  logic                  o_fifo_ready_m;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_sop;
  logic                  o_eop;
  logic                  i_ready;

  modport master (
    input  i_fifo_push,
    input  i_fifo_valid_m,
    input  i_fifo_dataout,
    input  i_ready,
    output o_fifo_ready_m,
    output o_valid,
    output o_data,
    output o_sop,
    output o_eop
  );

  modport slave (
    output i_fifo_push,
    output i_fifo_valid_m,
    output i_fifo_dataout,
    output i_ready,
    input  o_fifo_ready_m,
    input  o_valid,
    input  o_data,
    input  o_sop,
    input  o_eop
  );
endinterface

// File: rtl/fifo_burst_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_burst_rd_ctrl
// Read-side sequencer for a sync_fifo. Tracks FIFO occupancy, pops the FIFO
// in bursts of a programmed length and forwards the beats through a one-entry
// output register with start/end-of-packet markers. A programmable idle
// timeout flushes a partial burst so slow traffic does not sit in the FIFO.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous reset, active-high
//   i_enable     allows new bursts to start (never aborts a running burst)
//   i_burst_len  beats per burst, 0 -> 1, clamped to FIFO_DEPTH
//   i_timeout    idle cycles before a partial flush, 0 disables flushing
//   bus          FIFO pop handshake + downstream valid/ready stream
//   o_level      tracked FIFO occupancy
//   o_busy       burst in progress or output register occupied
// ---------------------------------------------------------------------------
module fifo_burst_rd_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int BLEN_WIDTH = ADDR_WIDTH + 1,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [BLEN_WIDTH-1:0] i_burst_len,
  input  logic [TMO_WIDTH-1:0]  i_timeout,
  fifo_burst_rd_ctrl_if.master  bus,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_busy
);

  localparam int LVL_W = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0]      DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [BLEN_WIDTH-1:0] DEPTH_B = BLEN_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [LVL_W-1:0]       level_reg;
  logic [TMO_WIDTH-1:0]   timer_reg, timer_next;
  logic [LVL_W-1:0]       beat_reg, beat_next;
  logic [LVL_W-1:0]       len_lat_reg, len_lat_next;
  logic [LVL_W-1:0]       len_eff;

  logic                   valid_reg;
  logic [DATA_WIDTH-1:0]  data_reg;
  logic                   sop_reg;
  logic                   eop_reg;

  logic                   pop;
  logic                   last_beat;
  logic                   push_inc;

  // Effective burst length: 0 behaves as 1, oversize requests clamp to depth.
  always_comb begin
    len_eff = LVL_W'(i_burst_len);
    if (i_burst_len == '0) begin
      len_eff = LVL_W'(1);
    end else if (i_burst_len > DEPTH_B) begin
      len_eff = DEPTH_L;
    end
  end

  assign pop       = bus.o_fifo_ready_m & bus.i_fifo_valid_m;
  assign last_beat = (beat_reg == len_lat_reg - LVL_W'(1));
  // A write into a full FIFO cannot raise the count any further.
  assign push_inc  = bus.i_fifo_push & (level_reg != DEPTH_L);

  // State register (plus the per-burst bookkeeping that moves with it)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      beat_reg    <= '0;
      len_lat_reg <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      beat_reg    <= beat_next;
      len_lat_reg <= len_lat_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    beat_next    = beat_reg;
    len_lat_next = len_lat_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_enable && (level_reg >= len_eff)) begin
          len_lat_next = len_eff;
          beat_next    = '0;
          state_next   = ST_BURST;
        end else if (i_enable && (level_reg != '0) && (i_timeout != '0)) begin
          timer_next = TMO_WIDTH'(1);
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_enable || (level_reg == '0)) begin
          timer_next = '0;
          state_next = ST_IDLE;
        end else if (level_reg >= len_eff) begin
          len_lat_next = len_eff;
          beat_next    = '0;
          state_next   = ST_BURST;
        end else if (timer_reg >= i_timeout) begin
          // Flush: send whatever is buffered as one short burst.
          len_lat_next = level_reg;
          beat_next    = '0;
          state_next   = ST_BURST;
        end else if (timer_reg != '1) begin
          timer_next = timer_reg + TMO_WIDTH'(1);
        end
      end
      ST_BURST: begin
        if (pop) begin
          if (last_beat) begin
            beat_next  = '0;
            timer_next = '0;
            state_next = ST_IDLE;
          end else begin
            beat_next = beat_reg + LVL_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic. The pop is gated on the output register being free (or
  // draining this cycle), which also keeps back-to-back bursts in order.
  always_comb begin
    bus.o_fifo_ready_m = (state_reg == ST_BURST) & bus.i_fifo_valid_m &
                         (~valid_reg | bus.i_ready);
    o_busy             = (state_reg == ST_BURST) | valid_reg;
  end

  // Occupancy tracking
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level_reg <= '0;
    end else if (push_inc && !pop) begin
      level_reg <= level_reg + LVL_W'(1);
    end else if (!bus.i_fifo_push && pop) begin
      level_reg <= level_reg - LVL_W'(1);
    end
  end

  // One-entry output register; contents hold while the consumer stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;
    end else if (pop) begin
      valid_reg <= 1'b1;
      data_reg  <= bus.i_fifo_dataout;
      sop_reg   <= (beat_reg == '0);
      eop_reg   <= last_beat;
    end else if (bus.i_ready && valid_reg) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.o_valid = valid_reg;
  assign bus.o_data  = data_reg;
  assign bus.o_sop   = sop_reg;
  assign bus.o_eop   = eop_reg;
  assign o_level     = level_reg;

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_rd_ctrl
// Drives the controller with a queue-based FIFO model and checks the beat
// stream against a list of expected beats built by chunking the pushed words
// into bursts of the effective length.
// ---------------------------------------------------------------------------
module tb_fifo_burst_rd_ctrl;

  localparam int FIFO_DEPTH = 16;
  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_enable;
  logic [4:0] i_burst_len;
  logic [7:0] i_timeout;
  logic [4:0] o_level;
  logic       o_busy;

  fifo_burst_rd_ctrl_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_burst_rd_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DATA_WIDTH(DATA_WIDTH),
    .TMO_WIDTH (8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_enable   (i_enable),
    .i_burst_len(i_burst_len),
    .i_timeout  (i_timeout),
    .bus        (bus.master),
    .o_level    (o_level),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] push_q[$];   // words still to be written into the FIFO
  logic [7:0] fifo_q[$];   // FIFO contents
  beat_t      exp_q[$];    // expected downstream beats, in order

  int    n_cmp = 0;
  int    n_err = 0;
  int    n_both = 0;
  int    n_stall = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_b;

  function automatic int len_eff_of(input int bl);
    if (bl == 0) return 1;
    if (bl > FIFO_DEPTH) return FIFO_DEPTH;
    return bl;
  endfunction

  // Queue n words for pushing and the beats they must come out as.
  task automatic plan(input int n, input int blen, input bit rnd, input logic [7:0] base);
    beat_t b;
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? 8'($urandom) : 8'(base + 8'(i));
      push_q.push_back(w);
      b.data = w;
      b.sop  = ((i % blen) == 0);
      b.eop  = ((i % blen) == blen - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic bit all_done();
    return (push_q.size() == 0) && (exp_q.size() == 0) && !o_busy;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 time unit later,
  // update the FIFO model just after the rising edge.
  task automatic do_cycle(input bit want_push, input bit rdy, output bit acc, output bit acc_eop);
    bit    push;
    bit    pop;
    int    lvl_before;
    beat_t b;
    push = want_push && (push_q.size() != 0) && (fifo_q.size() < FIFO_DEPTH);
    bus.i_fifo_push = push;
    bus.i_ready     = rdy;
    #1;
    pop     = bus.o_fifo_ready_m && bus.i_fifo_valid_m;
    acc     = bus.o_valid && rdy;
    acc_eop = bus.o_eop;
    if (bus.o_valid && !rdy) begin
      n_stall++;
      n_cmp++;
      if (bus.o_fifo_ready_m !== 1'b0) begin
        n_err++;
        $display("FAIL pop_during_stall: o_fifo_ready_m=%b required 0 (t=%0t)", bus.o_fifo_ready_m, $time);
      end
    end
    if (prev_stall) begin
      n_cmp++;
      if (bus.o_valid !== 1'b1 || {bus.o_data, bus.o_sop, bus.o_eop} !== prev_b) begin
        n_err++;
        $display("FAIL hold: valid=%b data=%h sop=%b eop=%b required valid=1 data=%h sop=%b eop=%b",
                 bus.o_valid, bus.o_data, bus.o_sop, bus.o_eop, prev_b.data, prev_b.sop, prev_b.eop);
      end
    end
    if (acc) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_beat: data=%h sop=%b eop=%b required no beat", bus.o_data, bus.o_sop, bus.o_eop);
      end else begin
        b = exp_q.pop_front();
        if ({bus.o_data, bus.o_sop, bus.o_eop} !== b) begin
          n_err++;
          $display("FAIL beat: data=%h sop=%b eop=%b required data=%h sop=%b eop=%b",
                   bus.o_data, bus.o_sop, bus.o_eop, b.data, b.sop, b.eop);
        end
      end
    end
    prev_stall = bus.o_valid && !rdy;
    prev_b     = {bus.o_data, bus.o_sop, bus.o_eop};
    lvl_before = int'(o_level);
    @(posedge i_clk);
    #1;
    if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (push) fifo_q.push_back(push_q.pop_front());
    n_cmp++;
    if (o_level !== 5'(fifo_q.size())) begin
      n_err++;
      $display("FAIL level: o_level=%0d required %0d", o_level, fifo_q.size());
    end
    if (push && pop) begin
      n_both++;
      n_cmp++;
      if (int'(o_level) != lvl_before) begin
        n_err++;
        $display("FAIL level_push_pop: o_level=%0d required %0d", o_level, lvl_before);
      end
    end
    bus.i_fifo_push    = 1'b0;
    bus.i_fifo_valid_m = (fifo_q.size() != 0);
    bus.i_fifo_dataout = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    @(negedge i_clk);
  endtask

  task automatic drain(input string name, input bit rnd_ready);
    bit acc, eop;
    int k;
    k = 0;
    while (!all_done() && k < 400) begin
      do_cycle(1'b1, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, acc, eop);
      k++;
    end
    n_cmp++;
    if (!all_done()) begin
      n_err++;
      $display("FAIL %s_timeout: %0d beats outstanding required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.o_valid, bus.o_sop, bus.o_eop, bus.o_fifo_ready_m, o_busy} !== 5'b0 ||
        bus.o_data !== 8'h00 || o_level !== 5'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b sop=%b eop=%b rdy_m=%b busy=%b data=%h level=%0d required all 0",
               bus.o_valid, bus.o_sop, bus.o_eop, bus.o_fifo_ready_m, o_busy, bus.o_data, o_level);
    end
  endtask

  task automatic test_basic();
    bit acc, eop, in_burst;
    int k, last_k;
    i_burst_len = 5'd4; i_timeout = 8'd0; i_enable = 1'b1;
    plan(8, 4, 1'b0, 8'hA0);
    in_burst = 1'b0; last_k = 0; k = 0;
    while (!all_done() && k < 100) begin
      do_cycle(1'b1, 1'b1, acc, eop);
      if (acc) begin
        if (in_burst) begin
          n_cmp++;
          if (k != last_k + 1) begin
            n_err++;
            $display("FAIL burst_gap: beat at cycle %0d required %0d", k, last_k + 1);
          end
        end
        in_burst = !eop;
        last_k   = k;
      end
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || o_level !== 5'd0) begin
      n_err++;
      $display("FAIL basic_end: pending=%0d level=%0d required 0 and 0", exp_q.size(), o_level);
    end
  endtask

  task automatic test_timeout();
    bit acc, eop;
    int seen, first;
    i_burst_len = 5'd4; i_timeout = 8'd0; i_enable = 1'b1;
    plan(3, 3, 1'b1, 8'h00);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      do_cycle(1'b1, 1'b1, acc, eop);
      if (acc) seen++;
    end
    n_cmp++;
    if (seen != 0 || o_level !== 5'd3) begin
      n_err++;
      $display("FAIL no_flush: beats=%0d level=%0d required 0 and 3", seen, o_level);
    end
    // Enter WAIT one cycle after the timeout is set, count timeout cycles
    // there, then one cycle for the pop to reach the output register.
    i_timeout = 8'd5;
    first = -1;
    for (int k = 0; k < 40 && first < 0; k++) begin
      do_cycle(1'b0, 1'b1, acc, eop);
      if (acc) first = k;
    end
    n_cmp++;
    if (first != 5 + 2) begin
      n_err++;
      $display("FAIL flush_latency: first beat after %0d cycles required %0d", first, 7);
    end
    drain("timeout", 1'b0);
    i_timeout = 8'd0;
  endtask

  task automatic test_backpressure();
    bit acc, eop;
    bit pat[4];
    int k, s0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    i_burst_len = 5'd4; i_timeout = 8'd0; i_enable = 1'b1;
    plan(4, 4, 1'b1, 8'h00);
    s0 = n_stall; k = 0;
    while (!all_done() && k < 100) begin
      do_cycle(1'b1, pat[k % 4], acc, eop);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || n_stall == s0) begin
      n_err++;
      $display("FAIL backpressure: pending=%0d stalls=%0d required 0 and >0", exp_q.size(), n_stall - s0);
    end
  endtask

  task automatic test_push_pop_overlap();
    bit acc, eop;
    int b0;
    i_burst_len = 5'd4; i_timeout = 8'd0; i_enable = 1'b0;
    plan(12, 4, 1'b1, 8'h00);
    for (int k = 0; k < 5; k++) do_cycle(1'b1, 1'b1, acc, eop);
    b0 = n_both;
    i_enable = 1'b1;
    drain("overlap", 1'b0);
    n_cmp++;
    if (n_both == b0) begin
      n_err++;
      $display("FAIL overlap: push+pop cycles=%0d required >0", n_both - b0);
    end
  endtask

  task automatic test_enable_drop();
    bit acc, eop;
    int beats, pops;
    i_burst_len = 5'd8; i_timeout = 8'd0; i_enable = 1'b1;
    plan(8, 8, 1'b1, 8'h00);
    beats = 0;
    for (int k = 0; k < 100 && !all_done(); k++) begin
      do_cycle(1'b1, 1'b1, acc, eop);
      if (acc) begin
        beats++;
        i_enable = 1'b0;
      end
    end
    n_cmp++;
    if (beats != 8 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL enable_drop: beats=%0d required 8", beats);
    end
    plan(8, 8, 1'b1, 8'h00);
    pops = 0;
    for (int k = 0; k < 30; k++) begin
      do_cycle(1'b1, 1'b1, acc, eop);
      if (acc || bus.o_fifo_ready_m) pops++;
    end
    n_cmp++;
    if (pops != 0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL disabled_idle: activity=%0d busy=%b required 0 and 0", pops, o_busy);
    end
    i_enable = 1'b1;
    drain("reenable", 1'b0);
  endtask

  task automatic test_reset_mid();
    bit acc, eop;
    int beats;
    i_burst_len = 5'd4; i_timeout = 8'd0; i_enable = 1'b1;
    plan(4, 4, 1'b1, 8'h00);
    beats = 0;
    for (int k = 0; k < 100 && beats < 2; k++) begin
      do_cycle(1'b1, 1'b1, acc, eop);
      if (acc) beats++;
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.o_valid, bus.o_sop, bus.o_eop, o_busy} !== 4'b0 || o_level !== 5'd0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b sop=%b eop=%b busy=%b level=%0d required all 0",
               bus.o_valid, bus.o_sop, bus.o_eop, o_busy, o_level);
    end
    // The FIFO is reset alongside the controller.
    fifo_q.delete(); push_q.delete(); exp_q.delete();
    prev_stall = 1'b0;
    bus.i_fifo_valid_m = 1'b0;
    bus.i_fifo_dataout = 8'h00;
    @(negedge i_clk);
    i_rst = 1'b0;
    do_cycle(1'b0, 1'b1, acc, eop);
    n_cmp++;
    if (o_busy !== 1'b0 || bus.o_fifo_ready_m !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: busy=%b rdy_m=%b required 0 and 0", o_busy, bus.o_fifo_ready_m);
    end
    plan(4, 4, 1'b1, 8'h00);
    drain("after_reset", 1'b0);
  endtask

  task automatic test_edge_len();
    i_timeout = 8'd0; i_enable = 1'b1;
    i_burst_len = 5'd0;
    plan(3, len_eff_of(0), 1'b1, 8'h00);
    drain("len0", 1'b0);
    i_burst_len = 5'd31;
    plan(16, len_eff_of(31), 1'b1, 8'h00);
    drain("len31", 1'b0);
  endtask

  task automatic test_random();
    int bl, le, nb;
    i_timeout = 8'd0; i_enable = 1'b1;
    for (int it = 0; it < 6; it++) begin
      bl = $urandom_range(0, 31);
      le = len_eff_of(bl);
      nb = $urandom_range(1, 3);
      i_burst_len = 5'(bl);
      plan(nb * le, le, 1'b1, 8'h00);
      drain("random", 1'b1);
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_enable = 1'b0;
    i_burst_len = 5'd4;
    i_timeout = 8'd0;
    bus.i_fifo_push = 1'b0;
    bus.i_fifo_valid_m = 1'b0;
    bus.i_fifo_dataout = 8'h00;
    bus.i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    test_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    test_basic();
    test_timeout();
    test_backpressure();
    test_push_pop_overlap();
    test_enable_drop();
    test_reset_mid();
    test_edge_len();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_burst_rd_ctrl.md
Name: fifo_burst_rd_ctrl

Overview:
Read-side sequencer for sync_fifo. It tracks FIFO occupancy and pops the FIFO in bursts of a programmed length. Each burst goes to a downstream valid/ready consumer with start-of-packet and end-of-packet markers. A programmable timeout flushes partial bursts, so low-rate traffic does not stall in the FIFO.

Parameters:
FIFO_DEPTH, 16, depth of the controlled sync_fifo
DATA_WIDTH, 8, data width
ADDR_WIDTH, $clog2(FIFO_DEPTH), FIFO address width; the level counter is ADDR_WIDTH+1 bits
BLEN_WIDTH, ADDR_WIDTH+1, width of i_burst_len
TMO_WIDTH, 8, width of the timeout counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_enable  in  1  permits new bursts to start; never aborts a burst already in progress
i_burst_len  in  BLEN_WIDTH  beats per burst; sampled at burst start; 0 is treated as 1; values above FIFO_DEPTH are clamped to FIFO_DEPTH
i_timeout  in  TMO_WIDTH  idle cycles before a partial flush; 0 disables flushing
i_fifo_push  in  1  one accepted FIFO write this cycle (i_valid_s & o_ready_s of the FIFO)
i_fifo_valid_m  in  1  FIFO not empty
i_fifo_dataout  in  DATA_WIDTH  FIFO head data, first-word-fall-through
o_fifo_ready_m  out  1  pop request to the FIFO
o_valid  out  1  downstream data valid
o_data  out  DATA_WIDTH  downstream data
o_sop  out  1  first beat of a burst
o_eop  out  1  last beat of a burst
i_ready  in  1  downstream accepts the beat
o_level  out  ADDR_WIDTH+1  tracked FIFO occupancy
o_busy  out  1  state is BURST, or o_valid=1

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE.
  - level, timer and beat counter = 0.
  - o_valid=o_sop=o_eop=0, o_data=0, o_fifo_ready_m=0, o_busy=0.
  - Reset mid-burst discards the output register and the remaining beats. The FIFO contents are not touched; the team resets the FIFO together with this block.
- Pop definition: pop = o_fifo_ready_m & i_fifo_valid_m.
- o_fifo_ready_m = (state==BURST) & i_fifo_valid_m & (~o_valid | i_ready). It is combinational and is never asserted outside BURST.
- Level update:
  - level += i_fifo_push, then -= pop; push and pop together leave level unchanged.
  - A push at level==FIFO_DEPTH does not increment.
  - A pop at level==0 cannot occur.
- Output register, 1 entry:
  - On pop: load o_data=i_fifo_dataout, o_valid=1, o_sop=(beat==0), o_eop=(beat==len_lat-1).
  - Else on i_ready&o_valid: o_valid=0.
  - Pop-to-o_valid latency is 1 cycle.
  - Full throughput is 1 beat/cycle while i_ready=1.
  - o_data/o_sop/o_eop hold stable while o_valid & ~i_ready.
- Effective length: len_eff = max(1, min(i_burst_len, FIFO_DEPTH)).
- FSM states: IDLE, WAIT, BURST.
- IDLE:
  - If i_enable & level>=len_eff: latch len_lat=len_eff, beat=0, go to BURST.
  - Else if i_enable & level>0 & i_timeout!=0: timer=1, go to WAIT.
- WAIT:
  - If ~i_enable or level==0: timer=0, go to IDLE.
  - Else if level>=len_eff: len_lat=len_eff, go to BURST.
  - Else if timer>=i_timeout: flush, len_lat=level, go to BURST.
  - Else timer++. The timer saturates and never wraps.
- BURST:
  - beat increments on each pop.
  - The pop with beat==len_lat-1 returns the FSM to IDLE and clears timer and beat.
  - i_enable=0 mid-burst: the burst completes.
  - i_fifo_valid_m=0 in BURST (inconsistent level): stall, with no pop and no error.
- Back-to-back bursts: IDLE may re-enter BURST the next cycle. The last beat of the previous burst may still be in the output register; pop gating preserves ordering.
- i_burst_len and i_timeout changes mid-burst have no effect until the next burst start or next WAIT evaluation.

Test Plan:
- Len 4, timeout 0, enable; push 8 words A0..A7 with i_ready=1. Required: two bursts of 4, each sop on A0/A4 and eop on A3/A7; no gaps within a burst; level returns to 0.
- Len 4, push 3 words, timeout 0. Required: no pop, o_valid stays 0, level=3. Then set timeout=5. Required: WAIT counts to 5, then one burst of 3 beats with sop on beat 0 and eop on beat 2.
- Downstream backpressure: len 4, 4 words, i_ready toggling 1,0,0,1. Required: o_data/o_sop/o_eop hold while stalled; o_fifo_ready_m=0 during stalls; exactly 4 beats in order.
- Simultaneous push and pop during a burst with level at 5. Required: level unchanged on cycles with both events; data order preserved.
- i_enable dropped after the first beat of an 8-beat burst. Required: all 8 beats delivered, eop on beat 8, then no new burst until re-enabled.
- i_rst pulsed mid-burst after 2 of 4 beats. Required: o_valid, o_sop, o_eop, o_busy and o_level go to 0 immediately (async); state=IDLE after release.
- Edge cases: i_burst_len=0 gives single-beat bursts with sop=eop=1; i_burst_len=31 with FIFO_DEPTH=16 clamps to 16.
